// File: rtl/ps2_line_conditioner_pkg.sv
// line_cond_pkg: shared constants and debounce exponent clamp for the line conditioner
// Provides DEBOUNCE_TIME_W, the default reset level and db_exp(d, mx) = min(d, mx).
package line_cond_pkg;
  localparam int DEBOUNCE_TIME_W = 5;
  localparam logic RESET_LEVEL_DEFAULT = 1'b1;
  function automatic logic [DEBOUNCE_TIME_W-1:0] db_exp(input logic [DEBOUNCE_TIME_W-1:0] d, input int unsigned mx);
    return (32'(d) > mx) ? DEBOUNCE_TIME_W'(mx) : d;
  endfunction
endpackage

// File: rtl/ps2_line_conditioner_channel.sv
// line_cond_channel: synchroniser, bypass mux, debouncer and edge strobes for one line
// Ports: clk, rst_n (sync, active-low), line_in (raw line), sync_en (1: synchronised input),
//        exp_d (clamped debounce exponent), cnt_clr (clear count, hold level),
//        line_out (debounced level), rise/fall (one-cycle edge pulses).
module line_cond_channel
  import line_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_MAX_LOG2 = 16,
  parameter logic USE_DB = 1'b1,
  parameter logic RESET_LEVEL = RESET_LEVEL_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  input  logic sync_en,
  input  logic [DEBOUNCE_TIME_W-1:0] exp_d,
  input  logic cnt_clr,
  output logic line_out,
  output logic rise,
  output logic fall
);
  localparam int CW = DB_MAX_LOG2 + 1;
  logic [SYNC_STAGES-1:0] chain;
  logic [CW-1:0] cnt, lim;
  logic cin, out_q, prev_q;
  // lim = N-1; an unmasked channel always uses N = 1, so d = 0 is just a register
  always_comb begin
    cin = sync_en ? chain[SYNC_STAGES-1] : line_in;
    lim = USE_DB ? (CW'(1) << exp_d) - CW'(1) : '0;
    line_out = out_q;
    rise = out_q & ~prev_q;
    fall = ~out_q & prev_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_LEVEL}};
      cnt <= '0;
      out_q <= RESET_LEVEL;
      prev_q <= RESET_LEVEL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], line_in};
      prev_q <= out_q;
      if (cnt_clr || cin == out_q) cnt <= '0;
      else if (cnt == lim) begin
        out_q <= cin;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/ps2_line_conditioner.sv
// ps2_line_conditioner: multi-channel synchronise/debounce/edge-detect for slow async lines
// Ports: clk, rst_n (sync, active-low), line_in[CHANNELS] (raw lines),
//        synchronizer_enable (1: synchronised path, 0: raw), debounce_time (exponent d),
//        line_out[CHANNELS] (conditioned levels), rise/fall[CHANNELS] (one-cycle edge pulses).
module ps2_line_conditioner
  import line_cond_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_MAX_LOG2 = 16,
  parameter logic [CHANNELS-1:0] DEBOUNCE_MASK = {CHANNELS{1'b1}},
  parameter logic RESET_LEVEL = RESET_LEVEL_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [CHANNELS-1:0] line_in,
  input  logic synchronizer_enable,
  input  logic [DEBOUNCE_TIME_W-1:0] debounce_time,
  output logic [CHANNELS-1:0] line_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);
  logic [DEBOUNCE_TIME_W-1:0] dt_q, exp_d;
  logic clr;
  // the exponent comes from the registered copy, so a new value takes effect one cycle
  // after the clear cycle it triggers
  always_comb begin
    clr = debounce_time != dt_q;
    exp_d = db_exp(dt_q, DB_MAX_LOG2);
  end
  always_ff @(posedge clk) dt_q <= !rst_n ? '0 : debounce_time;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    line_cond_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_MAX_LOG2(DB_MAX_LOG2),
      .USE_DB(DEBOUNCE_MASK[i]),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .line_in(line_in[i]),
      .sync_en(synchronizer_enable),
      .exp_d(exp_d),
      .cnt_clr(clr),
      .line_out(line_out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule
